// File: rtl/m_wb_pkg.sv
// Shared Wishbone constants and grant encodings for the two-master arbiter.
// Grant values double as the arbiter FSM state encoding.
package m_wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'b00,
        GNT_M0   = 2'b01,
        GNT_M1   = 2'b10
    } gnt_e;

endpackage

// File: rtl/m_wb_timeout.sv
// Bus watchdog: counts stalled strobe cycles, fires a one-cycle forced ACK, keeps a sticky fault flag.
// Latency: forced ACK is combinational in the cycle the count reaches TIMEOUT.
// Backpressure: none; the counter restarts whenever the strobe drops or the slave acks.
module m_wb_timeout #(
    parameter int TIMEOUT = 255,
    parameter int TOW     = $clog2(TIMEOUT + 1)
) (
    input  logic CLK_I,
    input  logic RST_N_I,
    input  logic stb,
    input  logic ack,
    input  logic toclr,
    output logic fack,
    output logic tofault
);

    logic [TOW-1:0] cnt;

    assign fack = stb & ~ack & (cnt == TOW'(TIMEOUT));

    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            cnt     <= '0;
            tofault <= 1'b0;
        end else begin
            // Clearing on fack keeps cnt at or below TIMEOUT, so it never wraps.
            if (!stb || ack || fack)
                cnt <= '0;
            else
                cnt <= cnt + TOW'(1);

            if (fack)
                tofault <= 1'b1;
            else if (toclr)
                tofault <= 1'b0;
        end
    end

endmodule

// File: rtl/m_wb_arb2.sv
// Two-master Wishbone classic arbiter: registered round-robin grant held for the whole CYC.
// Latency: grant one edge after request; data/ACK paths are combinational, no wait states.
// Backpressure: slave stalls pass straight through; watchdog forces a zero-data ACK after TIMEOUT.
module m_wb_arb2
    import m_wb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TOW     = $clog2(TIMEOUT + 1)
) (
    input  logic                CLK_I,
    input  logic                RST_N_I,

    input  logic                M0_CYC_I,
    input  logic                M0_STB_I,
    input  logic                M0_WE_I,
    input  logic [WB_ADR_W-1:0] M0_ADR_I,
    input  logic [WB_DAT_W-1:0] M0_DAT_I,
    input  logic [WB_SEL_W-1:0] M0_SEL_I,
    output logic [WB_DAT_W-1:0] M0_DAT_O,
    output logic                M0_ACK_O,

    input  logic                M1_CYC_I,
    input  logic                M1_STB_I,
    input  logic                M1_WE_I,
    input  logic [WB_ADR_W-1:0] M1_ADR_I,
    input  logic [WB_DAT_W-1:0] M1_DAT_I,
    input  logic [WB_SEL_W-1:0] M1_SEL_I,
    output logic [WB_DAT_W-1:0] M1_DAT_O,
    output logic                M1_ACK_O,

    output logic                CYC_O,
    output logic                STB_O,
    output logic                WE_O,
    output logic [WB_ADR_W-1:0] ADR_O,
    output logic [WB_DAT_W-1:0] DAT_O,
    output logic [WB_SEL_W-1:0] SEL_O,
    input  logic [WB_DAT_W-1:0] DAT_I,
    input  logic                ACK_I,

    output logic [1:0]          gnt,
    output logic                tofault,
    input  logic                toclr
);

    gnt_e state_q;
    gnt_e state_d;
    logic last_q;   // 0: master 0 was granted last, 1: master 1
    logic sel0;
    logic sel1;
    logic fack;

    always_comb begin
        state_d = state_q;
        case (state_q)
            GNT_IDLE: begin
                if (M0_CYC_I && M1_CYC_I)
                    state_d = last_q ? GNT_M0 : GNT_M1;
                else if (M0_CYC_I)
                    state_d = GNT_M0;
                else if (M1_CYC_I)
                    state_d = GNT_M1;
            end
            GNT_M0: begin
                if (!M0_CYC_I)
                    state_d = M1_CYC_I ? GNT_M1 : GNT_IDLE;
            end
            GNT_M1: begin
                if (!M1_CYC_I)
                    state_d = M0_CYC_I ? GNT_M0 : GNT_IDLE;
            end
            default: state_d = GNT_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            state_q <= GNT_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_d == GNT_M0)
                last_q <= 1'b0;
            else if (state_d == GNT_M1)
                last_q <= 1'b1;
        end
    end

    assign gnt  = state_q;
    assign sel0 = (state_q == GNT_M0);
    assign sel1 = (state_q == GNT_M1);

    always_comb begin
        CYC_O = 1'b0;
        STB_O = 1'b0;
        WE_O  = 1'b0;
        ADR_O = '0;
        DAT_O = '0;
        SEL_O = '0;
        if (sel0) begin
            CYC_O = M0_CYC_I;
            STB_O = M0_STB_I;
            WE_O  = M0_WE_I;
            ADR_O = M0_ADR_I;
            DAT_O = M0_DAT_I;
            SEL_O = M0_SEL_I;
        end else if (sel1) begin
            CYC_O = M1_CYC_I;
            STB_O = M1_STB_I;
            WE_O  = M1_WE_I;
            ADR_O = M1_ADR_I;
            DAT_O = M1_DAT_I;
            SEL_O = M1_SEL_I;
        end
    end

    // A forced ACK only happens with STB_O high, so it always lands on the granted master.
    assign M0_ACK_O = sel0 & (ACK_I | fack);
    assign M1_ACK_O = sel1 & (ACK_I | fack);
    assign M0_DAT_O = (sel0 && !fack) ? DAT_I : '0;
    assign M1_DAT_O = (sel1 && !fack) ? DAT_I : '0;

    m_wb_timeout #(
        .TIMEOUT (TIMEOUT),
        .TOW     (TOW)
    ) u_timeout (
        .CLK_I   (CLK_I),
        .RST_N_I (RST_N_I),
        .stb     (STB_O),
        .ack     (ACK_I),
        .toclr   (toclr),
        .fack    (fack),
        .tofault (tofault)
    );

endmodule

// File: tb/tb_m_wb_arb2.sv
// Directed bench for m_wb_arb2 with TIMEOUT=4: one table row per clock cycle, plus a timed watchdog sequence.
module tb_m_wb_arb2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m1_cyc, m1_stb;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack, m1_ack;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic [1:0]  gnt;
    logic        tofault;
    logic        toclr;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;
    localparam logic [31:0] W0 = 32'h1111_1111;
    localparam logic [31:0] W1 = 32'h2222_2222;

    always #5 clk = ~clk;

    m_wb_arb2 #(.TIMEOUT(4)) dut (
        .CLK_I    (clk),
        .RST_N_I  (rst_n),
        .M0_CYC_I (m0_cyc),
        .M0_STB_I (m0_stb),
        .M0_WE_I  (1'b0),
        .M0_ADR_I (A0),
        .M0_DAT_I (W0),
        .M0_SEL_I (4'hF),
        .M0_DAT_O (m0_dat_o),
        .M0_ACK_O (m0_ack),
        .M1_CYC_I (m1_cyc),
        .M1_STB_I (m1_stb),
        .M1_WE_I  (1'b1),
        .M1_ADR_I (A1),
        .M1_DAT_I (W1),
        .M1_SEL_I (4'h3),
        .M1_DAT_O (m1_dat_o),
        .M1_ACK_O (m1_ack),
        .CYC_O    (cyc_o),
        .STB_O    (stb_o),
        .WE_O     (we_o),
        .ADR_O    (adr_o),
        .DAT_O    (dat_o),
        .SEL_O    (sel_o),
        .DAT_I    (dat_i),
        .ACK_I    (ack_i),
        .gnt      (gnt),
        .tofault  (tofault),
        .toclr    (toclr)
    );

    typedef struct {
        logic        rst_n, c0, s0, c1, s1, ack, clr;
        logic [31:0] dat;
        logic [1:0]  gnt;
        logic        cyc, stb;
        logic [31:0] adr;
        logic        a0, a1;
        logic [31:0] d0, d1;
        logic        tf;
    } vec_t;

    vec_t vt[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (row %0d): got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, c0, s0, c1, s1, ack, clr, input logic [31:0] dat,
                       input logic [1:0] g, input logic cyc, stb, input logic [31:0] adr,
                       input logic a0, a1, input logic [31:0] d0, d1, input logic tf);
        vec_t v;
        v.rst_n = r; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack; v.clr = clr;
        v.dat = dat; v.gnt = g; v.cyc = cyc; v.stb = stb; v.adr = adr;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.tf = tf;
        vt.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int k;
        logic got;

        // Reset with both masters requesting; state is unknown before this first edge.
        rst_n = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        ack_i = 1'b0; dat_i = '0; toclr = 1'b0;
        @(posedge clk);

        //  rst c0 s0 c1 s1 ack clr dat            gnt   cyc stb adr a0 a1 d0             d1             tf
        add(0, 1, 1, 1, 1, 0, 0, 32'h0,          2'd0, 0, 0, 0,  0, 0, 0,             0,             0);
        add(0, 1, 1, 1, 1, 0, 0, 32'h0,          2'd0, 0, 0, 0,  0, 0, 0,             0,             0);
        add(1, 1, 1, 1, 1, 0, 0, 32'h0,          2'd0, 0, 0, 0,  0, 0, 0,             0,             0);
        // Master 0 wins first contention, read acked in its 2nd cycle.
        add(1, 1, 1, 1, 1, 0, 0, 32'h1234_5678,  2'd1, 1, 1, A0, 0, 0, 32'h1234_5678, 0,             0);
        add(1, 1, 1, 1, 1, 1, 0, 32'hDEAD_BEEF,  2'd1, 1, 1, A0, 1, 0, 32'hDEAD_BEEF, 0,             0);
        // Handovers with no idle cycles: 01 -> 10 -> 01 -> 10.
        add(1, 0, 0, 1, 1, 0, 0, 32'h0,          2'd1, 0, 0, A0, 0, 0, 0,             0,             0);
        add(1, 1, 1, 1, 1, 1, 0, 32'hCAFE_F00D,  2'd2, 1, 1, A1, 0, 1, 0,             32'hCAFE_F00D, 0);
        add(1, 1, 1, 0, 0, 0, 0, 32'h0,          2'd2, 0, 0, A1, 0, 0, 0,             0,             0);
        add(1, 1, 1, 1, 1, 1, 0, 32'h0000_A5A5,  2'd1, 1, 1, A0, 1, 0, 32'h0000_A5A5, 0,             0);
        add(1, 0, 0, 1, 1, 0, 0, 32'h0,          2'd1, 0, 0, A0, 0, 0, 0,             0,             0);
        // Master 1 strobes a dead slave: forced zero-data ACK in the 5th cycle.
        add(1, 0, 0, 1, 1, 0, 0, 32'h0,          2'd2, 1, 1, A1, 0, 0, 0,             0,             0);
        for (int i = 0; i < 3; i++)
            add(1, 0, 0, 1, 1, 0, 0, 32'h7777_7777, 2'd2, 1, 1, A1, 0, 0, 0,         32'h7777_7777, 0);
        add(1, 0, 0, 1, 1, 0, 0, 32'h7777_7777,  2'd2, 1, 1, A1, 0, 1, 0,             0,             0);
        add(1, 0, 0, 0, 0, 0, 0, 32'h0,          2'd2, 0, 0, A1, 0, 0, 0,             0,             1);
        add(1, 0, 0, 0, 0, 0, 1, 32'h0,          2'd0, 0, 0, 0,  0, 0, 0,             0,             1);
        // toclr took effect; a slave ACK while idle is ignored.
        add(1, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF,  2'd0, 0, 0, 0,  0, 0, 0,             0,             0);
        // Two back-to-back timeouts; the second coincides with toclr and must keep the flag set.
        add(1, 0, 0, 1, 1, 0, 0, 32'h0,          2'd0, 0, 0, 0,  0, 0, 0,             0,             0);
        for (int i = 0; i < 4; i++)
            add(1, 0, 0, 1, 1, 0, 0, 32'h0,      2'd2, 1, 1, A1, 0, 0, 0,             0,             0);
        add(1, 0, 0, 1, 1, 0, 0, 32'h0,          2'd2, 1, 1, A1, 0, 1, 0,             0,             0);
        for (int i = 0; i < 4; i++)
            add(1, 0, 0, 1, 1, 0, 0, 32'h0,      2'd2, 1, 1, A1, 0, 0, 0,             0,             1);
        add(1, 0, 0, 1, 1, 0, 1, 32'h0,          2'd2, 1, 1, A1, 0, 1, 0,             0,             1);
        add(1, 0, 0, 1, 1, 0, 0, 32'h0,          2'd2, 1, 1, A1, 0, 0, 0,             0,             1);
        // Reset mid-burst of master 1, then contention goes to master 0.
        add(0, 0, 0, 1, 1, 0, 0, 32'h0,          2'd2, 1, 1, A1, 0, 0, 0,             0,             1);
        add(1, 1, 1, 1, 1, 0, 0, 32'h0,          2'd0, 0, 0, 0,  0, 0, 0,             0,             0);
        add(1, 1, 1, 1, 1, 0, 0, 32'h0,          2'd1, 1, 1, A0, 0, 0, 0,             0,             0);

        foreach (vt[i]) begin
            #1;
            rst_n = vt[i].rst_n; m0_cyc = vt[i].c0; m0_stb = vt[i].s0;
            m1_cyc = vt[i].c1; m1_stb = vt[i].s1; ack_i = vt[i].ack;
            toclr = vt[i].clr; dat_i = vt[i].dat;
            #3;
            chk("gnt",      i, {30'b0, gnt},     {30'b0, vt[i].gnt});
            chk("CYC_O",    i, {31'b0, cyc_o},   {31'b0, vt[i].cyc});
            chk("STB_O",    i, {31'b0, stb_o},   {31'b0, vt[i].stb});
            chk("ADR_O",    i, adr_o,            vt[i].adr);
            chk("M0_ACK_O", i, {31'b0, m0_ack},  {31'b0, vt[i].a0});
            chk("M1_ACK_O", i, {31'b0, m1_ack},  {31'b0, vt[i].a1});
            chk("M0_DAT_O", i, m0_dat_o,         vt[i].d0);
            chk("M1_DAT_O", i, m1_dat_o,         vt[i].d1);
            chk("tofault",  i, {31'b0, tofault}, {31'b0, vt[i].tf});
            @(posedge clk);
        end

        // Master 0 watchdog: measure the cycle of the forced ACK after the strobe first appears.
        #1;
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        ack_i = 1'b0; toclr = 1'b0; dat_i = 32'hBBBB_BBBB;
        @(posedge clk);
        #1;
        m0_cyc = 1'b1; m0_stb = 1'b1;
        k = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(posedge clk);
            #4;
            k++;
            if (k == 1) begin
                chk("seq WE_O",  100, {31'b0, we_o}, 32'd0);
                chk("seq DAT_O", 100, dat_o,         W0);
                chk("seq SEL_O", 100, {28'b0, sel_o}, 32'hF);
            end
            if (m0_ack) begin
                got = 1'b1;
                chk("seq fack M0_DAT_O", 100, m0_dat_o,           32'h0);
                chk("seq fack M1_ACK_O", 100, {31'b0, m1_ack},    32'd0);
                chk("seq fack tofault",  100, {31'b0, tofault},   32'd0);
            end
        end
        chk("seq fack cycle", 100, k, 32'd5);
        @(posedge clk);
        #4;
        chk("seq tofault set", 100, {31'b0, tofault}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/m_wb_arb2.md
# m_wb_arb2

Two-master Wishbone B4 classic-cycle arbiter that shares one slave bus between the midgetv core (master 0) and a second master (master 1, loader/debug DMA). It holds a registered grant for the whole CYC, uses round-robin on contention, and has a bus-timeout watchdog. The watchdog forces a zero-data ACK to the stalled master and sets a sticky flag, so a dead slave never hangs the core. It sits between `m_midgetv_core` and the system I/O/SRAM decode.

## Interface
Parameters:
- `TIMEOUT`, 255, number of stalled cycles (slave `STB_O`=1, `ACK_I`=0) tolerated before a forced ACK; legal range 2..65535.
- `TOW`, `$clog2(TIMEOUT+1)`, counter width; derived, not to be overridden.

Ports:
- `CLK_I`, in, 1, single clock.
- `RST_N_I`, in, 1, reset; synchronous, active-low.
- `M0_CYC_I`, `M0_STB_I`, `M0_WE_I`, in, 1 each, master 0 Wishbone controls.
- `M0_ADR_I`, `M0_DAT_I`, in, 32 each; `M0_SEL_I`, in, 4; master 0 address, write data and byte selects.
- `M0_DAT_O`, out, 32, read data to master 0.
- `M0_ACK_O`, out, 1, acknowledge to master 0.
- `M1_*`, same set of ports and widths as `M0_*`, for master 1.
- `CYC_O`, `STB_O`, `WE_O`, out, 1 each; `ADR_O`, `DAT_O`, out, 32 each; `SEL_O`, out, 4; slave side.
- `DAT_I`, in, 32; `ACK_I`, in, 1; slave side.
- `gnt`, out, 2, current grant: 00 idle, 01 master 0, 10 master 1.
- `tofault`, out, 1, sticky timeout flag.
- `toclr`, in, 1, clears `tofault`.

## Operation
- Grant FSM states:
  - IDLE: no grant.
    - Only `M0_CYC_I` high → GNT0. Only `M1_CYC_I` high → GNT1.
    - Both high → grant the master that is not `last`.
  - GNT0/GNT1: the grant holds while that master's `CYC_I`=1.
    - When it drops and the other master's `CYC_I`=1, hand over directly to the other grant state with no IDLE cycle.
    - Otherwise go to IDLE.
  - `last` updates to the granted master on every entry to GNT0/GNT1.
- Slave-side outputs are a combinational mux of the granted master, selected by the registered `gnt`.
  - `CYC_O` and `STB_O` are ANDed with the grant; in IDLE all slave outputs are 0.
- Master-side responses:
  - `Mx_ACK_O` = `ACK_I` & (grant==x), OR the forced ACK.
  - `Mx_DAT_O` = `DAT_I` when granted and not forced, otherwise 0.
  - The non-granted master sees ACK=0 and DAT=0.
- Timeout watchdog (`cnt`, TOW bits):
  - Clears when `STB_O`=0 or `ACK_I`=1; otherwise increments.
  - When `cnt`==TIMEOUT and `ACK_I`=0: force ACK to the granted master for exactly that cycle with data 32'h0, set `tofault`, clear `cnt`.
  - `cnt` never wraps.
- `tofault`: set by a forced ACK, cleared by `toclr`. If both occur in the same cycle, set wins.
- Reset (`RST_N_I`=0 at a clock edge): `gnt`=00, `last`=1 (master 0 wins the first contention), `cnt`=0, `tofault`=0.
  - All slave outputs and ACKs therefore read 0 in the following cycle.
  - A reset in the middle of a cycle aborts it; the slave sees `CYC_O` fall.

## Timing
- Arbitration latency: a request in IDLE at edge k gives `gnt` valid after edge k+1. The first slave `STB_O` appears in cycle k+1.
- Handover: master 0 drops `CYC_I` in cycle n while master 1 is requesting → `gnt`=10 from cycle n+1, with zero idle cycles between.
- Data and ACK paths are purely combinational through the muxes, adding no wait states. Every slave ACK reaches the granted master in the same cycle.
- Forced ACK arrives in cycle TIMEOUT+1 after `STB_O` first rises with no ACK.
- A master may not drop `CYC_I` mid-transfer. If it does, the grant still follows `CYC_I` and the slave sees `CYC_O` fall.
- An `ACK_I` arriving while `gnt`=00 is ignored.

## Structure
- Shared package `m_wb_pkg` holds:
  - the grant encodings `GNT_IDLE`, `GNT_M0`, `GNT_M1`;
  - the Wishbone width constants ADR=32, DAT=32, SEL=4.
- One sub-module, `m_wb_timeout`, contains the cycle counter, compare, forced-ACK pulse and sticky flag, with `TIMEOUT` as its parameter. The arbiter top keeps the FSM and the muxes.

## Test plan
- Reset held low for 3 cycles with both masters requesting → all outputs 0. After release, `gnt`=01 one cycle later.
- Master 0 single read of 0x0000_1000; slave acks in its 2nd cycle with 0xDEADBEEF → `M0_DAT_O`=0xDEADBEEF, `M0_ACK_O` pulses once, `M1_ACK_O` stays 0.
- Both masters hold `CYC_I` continuously, each releasing after one transfer → grants alternate 01,10,01,10 with no IDLE cycles between.
- TIMEOUT=4, master 1 strobes and the slave never acks → `M1_ACK_O`=1 in the 5th cycle with data 0, `tofault`=1. Pulsing `toclr` clears it.
- `tofault`=1 while `toclr` is pulsed and another timeout fires in the same cycle → `tofault` stays 1.
- Reset asserted while master 1 is granted mid-burst → `CYC_O`=0 and `gnt`=00 the next cycle. The next contention goes to master 0.
